// File: rtl/i2c_slave_byte_ctrl.sv
// I2C slave byte-level controller.
// Tracks address, write and read phases from pre-synchronised SCL/SDA events,
// drives the SDA pull-down for ACK and read data, and steers an external
// 4-bit bit counter through counter_en / counter_clr.
module i2c_slave_byte_ctrl #(
    parameter logic [6:0] SLAVE_ADDR = 7'h48
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       scl_rise,
    input  logic       scl_fall,
    input  logic       start_det,
    input  logic       stop_det,
    input  logic       sda_in,
    input  logic       tx_eq8,
    input  logic [7:0] tx_data,
    output logic       counter_en,
    output logic       counter_clr,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        WR_DATA  = 3'd3,
        WR_ACK   = 3'd4,
        RD_DATA  = 3'd5,
        RD_ACK   = 3'd6
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic       r_rw, w_rw_nxt;
    logic       r_ack, w_ack_nxt;
    logic       r_sda_oe, w_sda_oe_nxt;
    logic [7:0] r_rx_data, w_rx_data_nxt;
    logic       r_rx_valid, w_rx_valid_nxt;
    logic       w_cnt_en, w_cnt_clr, w_tx_req;

    // State and datapath registers; reset aborts any transfer in flight.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state    <= IDLE;
            r_shift    <= 8'h00;
            r_rw       <= 1'b0;
            r_ack      <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_rw       <= w_rw_nxt;
            r_ack      <= w_ack_nxt;
            r_sda_oe   <= w_sda_oe_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
        end
    end

    // Next-state and control decode: STOP beats START beats SCL edges.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_rw_nxt       = r_rw;
        w_ack_nxt      = r_ack;
        w_sda_oe_nxt   = r_sda_oe;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_cnt_en       = 1'b0;
        w_cnt_clr      = 1'b0;
        w_tx_req       = 1'b0;
        if (stop_det) begin
            w_state_nxt  = IDLE;
            w_cnt_clr    = 1'b1;
            w_sda_oe_nxt = 1'b0;
        end else if (start_det) begin
            w_state_nxt  = ADDR;
            w_cnt_clr    = 1'b1;
            w_sda_oe_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        w_shift_nxt = {r_shift[6:0], sda_in};
                        w_cnt_en    = 1'b1;
                    end else if (scl_fall && tx_eq8) begin
                        w_cnt_clr = 1'b1;
                        if (r_shift[7:1] == SLAVE_ADDR) begin
                            w_state_nxt  = ADDR_ACK;
                            w_sda_oe_nxt = 1'b1;
                            w_rw_nxt     = r_shift[0];
                        end else begin
                            w_state_nxt  = IDLE;
                            w_sda_oe_nxt = 1'b0;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (r_rw) begin
                            // First read byte: put its MSB on the bus right away.
                            w_state_nxt  = RD_DATA;
                            w_tx_req     = 1'b1;
                            w_shift_nxt  = tx_data;
                            w_sda_oe_nxt = ~tx_data[7];
                        end else begin
                            w_state_nxt  = WR_DATA;
                            w_sda_oe_nxt = 1'b0;
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_rise) begin
                        w_shift_nxt = {r_shift[6:0], sda_in};
                        w_cnt_en    = 1'b1;
                    end else if (scl_fall && tx_eq8) begin
                        w_rx_data_nxt  = r_shift;
                        w_rx_valid_nxt = 1'b1;
                        w_cnt_clr      = 1'b1;
                        w_state_nxt    = WR_ACK;
                        w_sda_oe_nxt   = 1'b1;
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        w_sda_oe_nxt = 1'b0;
                        w_state_nxt  = WR_DATA;
                    end
                end
                RD_DATA: begin
                    if (scl_rise) begin
                        w_cnt_en = 1'b1;
                    end else if (scl_fall) begin
                        if (tx_eq8) begin
                            w_cnt_clr    = 1'b1;
                            w_sda_oe_nxt = 1'b0;
                            w_state_nxt  = RD_ACK;
                        end else begin
                            w_shift_nxt  = {r_shift[6:0], 1'b0};
                            w_sda_oe_nxt = ~r_shift[6];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        w_ack_nxt = sda_in;
                    end else if (scl_fall) begin
                        if (!r_ack) begin
                            w_state_nxt  = RD_DATA;
                            w_tx_req     = 1'b1;
                            w_shift_nxt  = tx_data;
                            w_sda_oe_nxt = ~tx_data[7];
                        end else begin
                            w_state_nxt  = IDLE;
                            w_sda_oe_nxt = 1'b0;
                        end
                    end
                end
                default: begin
                    w_state_nxt  = IDLE;
                    w_sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    // Pulse outputs are forced low while reset is held; clear beats increment.
    assign counter_en  = presetn & w_cnt_en & ~w_cnt_clr;
    assign counter_clr = presetn & w_cnt_clr;
    assign tx_req      = presetn & w_tx_req;
    assign sda_oe      = r_sda_oe;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_i2c_slave_byte_ctrl.sv
// Self-checking bench for i2c_slave_byte_ctrl: transaction-level master
// stimulus with a behavioural model of the expected bus responses.
module tb_i2c_slave_byte_ctrl;

    logic       pclk = 1'b0;
    logic       presetn;
    logic       scl_rise, scl_fall, start_det, stop_det, sda_in;
    logic       tx_eq8;
    logic [7:0] tx_data;
    logic       counter_en, counter_clr, sda_oe, rx_valid, tx_req, busy;
    logic [7:0] rx_data;

    int n_checks = 0;
    int n_fail   = 0;

    int         rxv_cnt  = 0;
    int         txr_cnt  = 0;
    int         both_cnt = 0;
    logic [7:0] rx_log [64];
    logic [3:0] bit_cnt;
    logic [7:0] buf_q [8];
    logic [7:0] exp_rx_last;

    i2c_slave_byte_ctrl #(.SLAVE_ADDR(7'h48)) dut (
        .pclk(pclk), .presetn(presetn),
        .scl_rise(scl_rise), .scl_fall(scl_fall),
        .start_det(start_det), .stop_det(stop_det),
        .sda_in(sda_in), .tx_eq8(tx_eq8), .tx_data(tx_data),
        .counter_en(counter_en), .counter_clr(counter_clr),
        .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_req(tx_req), .busy(busy)
    );

    always #5 pclk = ~pclk;

    // External 4-bit bit counter the controller steers.
    always @(posedge pclk or negedge presetn) begin
        if (!presetn)         bit_cnt <= 4'd0;
        else if (counter_clr) bit_cnt <= 4'd0;
        else if (counter_en)  bit_cnt <= bit_cnt + 4'd1;
    end
    assign tx_eq8 = (bit_cnt == 4'd8);

    // Pulse monitor: logs received bytes and counts requests.
    always @(posedge pclk) begin
        if (rx_valid) begin
            rx_log[rxv_cnt % 64] <= rx_data;
            rxv_cnt <= rxv_cnt + 1;
        end
        if (tx_req) txr_cnt <= txr_cnt + 1;
        if (counter_en && counter_clr) both_cnt <= both_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    // One SCL clock; returns sda_oe as seen while SCL is high.
    task automatic i2c_bit(input logic b, output logic oe);
        sda_in = b;
        tick(2);
        scl_rise = 1'b1; tick(1); scl_rise = 1'b0;
        tick(2);
        oe = sda_oe;
        scl_fall = 1'b1; tick(1); scl_fall = 1'b0;
        tick(2);
    endtask

    task automatic i2c_byte(input logic [7:0] b, output logic [7:0] oev);
        logic o;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(b[i], o);
            oev[i] = o;
        end
    endtask

    task automatic bus_start();
        start_det = 1'b1; tick(1); start_det = 1'b0; tick(1);
    endtask

    task automatic bus_stop();
        stop_det = 1'b1; tick(1); stop_det = 1'b0; tick(1);
    endtask

    // Master write of buf_q[0..n-1] to addr; model says ACK only on a match.
    task automatic do_write(input logic [7:0] addr, input int n);
        logic [7:0] oev;
        logic       o, match;
        int         rx0;
        match = (addr[7:1] == 7'h48);
        rx0   = rxv_cnt;
        bus_start();
        i2c_byte(addr, oev);
        n_checks++; if (oev !== 8'h00) begin n_fail++; $display("FAIL wr_addr_oe: got %b want 00000000", oev); end
        n_checks++; if (busy !== match) begin n_fail++; $display("FAIL wr_busy_after_addr: got %b want %b", busy, match); end
        i2c_bit(1'b1, o);
        n_checks++; if (o !== match) begin n_fail++; $display("FAIL wr_addr_ack: got %b want %b", o, match); end
        for (int k = 0; k < n; k++) begin
            i2c_byte(buf_q[k], oev);
            n_checks++; if (oev !== 8'h00) begin n_fail++; $display("FAIL wr_data_oe: got %b want 00000000", oev); end
            i2c_bit(1'b1, o);
            n_checks++; if (o !== match) begin n_fail++; $display("FAIL wr_data_ack: byte %0d got %b want %b", k, o, match); end
            if (match) exp_rx_last = buf_q[k];
        end
        bus_stop();
        n_checks++; if (busy !== 1'b0 || sda_oe !== 1'b0) begin n_fail++; $display("FAIL wr_after_stop: busy=%b sda_oe=%b want 0 0", busy, sda_oe); end
        n_checks++; if (rxv_cnt - rx0 !== (match ? n : 0)) begin n_fail++; $display("FAIL wr_rx_valid_count: got %0d want %0d", rxv_cnt - rx0, match ? n : 0); end
        if (match) begin
            for (int k = 0; k < n; k++) begin
                n_checks++; if (rx_log[(rx0 + k) % 64] !== buf_q[k]) begin n_fail++; $display("FAIL wr_rx_byte: idx %0d got %h want %h", k, rx_log[(rx0 + k) % 64], buf_q[k]); end
            end
        end
        n_checks++; if (rx_data !== exp_rx_last) begin n_fail++; $display("FAIL wr_rx_data_hold: got %h want %h", rx_data, exp_rx_last); end
    endtask

    // Master read of n bytes (slave serves buf_q[]), ACK all but the last.
    task automatic do_read(input logic [7:0] addr, input int n);
        logic [7:0] oev, exp_oev;
        logic       o, match;
        int         tx0, rx0;
        match   = (addr[7:1] == 7'h48);
        tx0     = txr_cnt;
        rx0     = rxv_cnt;
        tx_data = buf_q[0];
        bus_start();
        i2c_byte(addr, oev);
        n_checks++; if (oev !== 8'h00) begin n_fail++; $display("FAIL rd_addr_oe: got %b want 00000000", oev); end
        i2c_bit(1'b1, o);
        n_checks++; if (o !== match) begin n_fail++; $display("FAIL rd_addr_ack: got %b want %b", o, match); end
        for (int k = 0; k < n; k++) begin
            i2c_byte(8'hFF, oev);
            exp_oev = match ? ~buf_q[k] : 8'h00;
            n_checks++; if (oev !== exp_oev) begin n_fail++; $display("FAIL rd_pattern: byte %0d got %b want %b", k, oev, exp_oev); end
            if (k + 1 < n) tx_data = buf_q[k + 1];
            i2c_bit(k == n - 1, o);
            n_checks++; if (o !== 1'b0) begin n_fail++; $display("FAIL rd_ack_release: got %b want 0", o); end
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_idle_after_nack: busy got %b want 0", busy); end
        bus_stop();
        n_checks++; if (txr_cnt - tx0 !== (match ? n : 0)) begin n_fail++; $display("FAIL rd_tx_req_count: got %0d want %0d", txr_cnt - tx0, match ? n : 0); end
        n_checks++; if (rxv_cnt !== rx0) begin n_fail++; $display("FAIL rd_no_rx_valid: got %0d want %0d", rxv_cnt, rx0); end
    endtask

    task automatic test_reset();
        logic [7:0] oev;
        logic       o;
        int         rx0;
        presetn = 1'b0; scl_rise = 1'b0; scl_fall = 1'b0;
        start_det = 1'b0; stop_det = 1'b0; sda_in = 1'b1; tx_data = 8'h00;
        exp_rx_last = 8'h00;
        tick(3);
        start_det = 1'b1; #1;
        n_checks++; if (counter_clr !== 1'b0 || counter_en !== 1'b0 || tx_req !== 1'b0) begin n_fail++; $display("FAIL rst_pulses: clr=%b en=%b txreq=%b want 0 0 0", counter_clr, counter_en, tx_req); end
        n_checks++; if (sda_oe !== 1'b0 || busy !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 8'h00) begin n_fail++; $display("FAIL rst_outputs: oe=%b busy=%b rxv=%b rxd=%h want 0 0 0 00", sda_oe, busy, rx_valid, rx_data); end
        tick(1); start_det = 1'b0;
        presetn = 1'b1;
        tick(2);
        rx0 = rxv_cnt;
        i2c_byte(8'h90, oev);
        i2c_bit(1'b1, o);
        n_checks++; if (oev !== 8'h00 || o !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_ignore_scl: oe=%b ack=%b busy=%b want 0", oev, o, busy); end
        n_checks++; if (rxv_cnt !== rx0) begin n_fail++; $display("FAIL rst_ignore_rxv: got %0d want %0d", rxv_cnt, rx0); end
    endtask

    task automatic test_write();
        buf_q[0] = 8'hA5;
        do_write(8'h90, 1);
    endtask

    task automatic test_addr_mismatch();
        buf_q[0] = 8'h55;
        do_write(8'h92, 1);
    endtask

    task automatic test_read();
        buf_q[0] = 8'h3C;
        buf_q[1] = 8'hFF;
        do_read(8'h91, 2);
    endtask

    task automatic test_repeated_start();
        logic [7:0] oev, d;
        logic       o;
        int         rx0;
        rx0 = rxv_cnt;
        bus_start();
        i2c_byte(8'h90, oev);
        i2c_bit(1'b1, o);
        for (int i = 0; i < 4; i++) i2c_bit(1'($urandom_range(0, 1)), o);
        start_det = 1'b1; #1;
        n_checks++; if (counter_clr !== 1'b1 || counter_en !== 1'b0) begin n_fail++; $display("FAIL rs_clr: clr=%b en=%b want 1 0", counter_clr, counter_en); end
        tick(1); start_det = 1'b0;
        n_checks++; if (busy !== 1'b1 || sda_oe !== 1'b0) begin n_fail++; $display("FAIL rs_state: busy=%b oe=%b want 1 0", busy, sda_oe); end
        tick(1);
        i2c_byte(8'h90, oev);
        i2c_bit(1'b1, o);
        n_checks++; if (o !== 1'b1) begin n_fail++; $display("FAIL rs_new_addr_ack: got %b want 1", o); end
        d = 8'($urandom);
        i2c_byte(d, oev);
        i2c_bit(1'b1, o);
        bus_stop();
        exp_rx_last = d;
        n_checks++; if (rxv_cnt - rx0 !== 1) begin n_fail++; $display("FAIL rs_rx_count: got %0d want 1", rxv_cnt - rx0); end
        n_checks++; if (rx_data !== d) begin n_fail++; $display("FAIL rs_rx_data: got %h want %h", rx_data, d); end
    endtask

    task automatic test_start_stop();
        logic [7:0] oev, d;
        logic       o;
        int         rx0;
        rx0 = rxv_cnt;
        bus_start();
        i2c_byte(8'h90, oev);
        i2c_bit(1'b1, o);
        for (int i = 0; i < 3; i++) i2c_bit(1'($urandom_range(0, 1)), o);
        start_det = 1'b1; stop_det = 1'b1; #1;
        n_checks++; if (counter_clr !== 1'b1) begin n_fail++; $display("FAIL ss_clr: got %b want 1", counter_clr); end
        tick(1); start_det = 1'b0; stop_det = 1'b0;
        n_checks++; if (busy !== 1'b0 || sda_oe !== 1'b0) begin n_fail++; $display("FAIL ss_idle: busy=%b oe=%b want 0 0", busy, sda_oe); end
        i2c_byte(8'h90, oev);
        i2c_bit(1'b1, o);
        n_checks++; if (oev !== 8'h00 || o !== 1'b0 || busy !== 1'b0 || rxv_cnt !== rx0) begin n_fail++; $display("FAIL ss_ignore: oe=%b ack=%b busy=%b rxv=%0d want 0 0 0 %0d", oev, o, busy, rxv_cnt, rx0); end
        // STOP while the slave is holding the data ACK low.
        bus_start();
        i2c_byte(8'h90, oev);
        i2c_bit(1'b1, o);
        d = 8'($urandom);
        i2c_byte(d, oev);
        exp_rx_last = d;
        n_checks++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL stop_ack_drive: got %b want 1", sda_oe); end
        bus_stop();
        n_checks++; if (sda_oe !== 1'b0 || busy !== 1'b0 || rx_data !== d) begin n_fail++; $display("FAIL stop_in_ack: oe=%b busy=%b rxd=%h want 0 0 %h", sda_oe, busy, rx_data, d); end
    endtask

    task automatic test_reset_in_ack();
        logic [7:0] oev, d;
        logic       o;
        int         rx0;
        rx0 = rxv_cnt;
        bus_start();
        i2c_byte(8'h90, oev);
        i2c_bit(1'b1, o);
        d = 8'($urandom);
        i2c_byte(d, oev);
        n_checks++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL ra_ack_drive: got %b want 1", sda_oe); end
        #2 presetn = 1'b0; #1;
        exp_rx_last = 8'h00;
        n_checks++; if (sda_oe !== 1'b0 || busy !== 1'b0 || rx_data !== 8'h00 || rx_valid !== 1'b0) begin n_fail++; $display("FAIL ra_async: oe=%b busy=%b rxd=%h rxv=%b want 0 0 00 0", sda_oe, busy, rx_data, rx_valid); end
        tick(2);
        presetn = 1'b1;
        tick(1);
        i2c_byte(8'h90, oev);
        i2c_bit(1'b1, o);
        n_checks++; if (oev !== 8'h00 || o !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL ra_ignore: oe=%b ack=%b busy=%b want 0", oev, o, busy); end
        n_checks++; if (rxv_cnt - rx0 !== 1 || rx_data !== 8'h00) begin n_fail++; $display("FAIL ra_rx: count=%0d rxd=%h want 1 00", rxv_cnt - rx0, rx_data); end
    endtask

    task automatic test_random_write();
        logic [6:0] a;
        int         n;
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) buf_q[k] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                a = 7'($urandom);
                if (a == 7'h48) a = 7'h49;
                do_write({a, 1'($urandom_range(0, 1))}, n);
            end else begin
                do_write(8'h90, n);
            end
        end
    endtask

    task automatic test_random_read();
        logic [6:0] a;
        int         n;
        for (int t = 0; t < 5; t++) begin
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) buf_q[k] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                a = 7'($urandom);
                if (a == 7'h48) a = 7'h21;
                do_read({a, 1'b1}, n);
            end else begin
                do_read(8'h91, n);
            end
        end
    endtask

    task automatic test_back_to_back();
        buf_q[0] = 8'h12; buf_q[1] = 8'h34;
        do_write(8'h90, 2);
        buf_q[0] = 8'h80; buf_q[1] = 8'h01; buf_q[2] = 8'h00;
        do_read(8'h91, 3);
        n_checks++; if (both_cnt !== 0) begin n_fail++; $display("FAIL en_clr_overlap: got %0d cycles want 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_addr_mismatch();
        test_read();
        test_repeated_start();
        test_start_stop();
        test_reset_in_ack();
        test_random_write();
        test_random_read();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
